// File: rtl/ctrl_pkg.sv
// Shared control-path definitions for the 5-stage MIPS core: opcodes, ALU ops
// and the nested control bundle that each pipeline stage strips as it advances.
package ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;

  // Field order is shared with the hazard unit and datapath; outer layers drop off per stage.
  typedef struct packed {
    logic regWrite;
    logic memtoReg;
    logic link;
  } wbCtrlT;

  typedef struct packed {
    logic   memWrite;
    wbCtrlT wb;
  } memCtrlT;

  typedef struct packed {
    logic               regDst;
    logic               aluSrc;
    logic [ALUOP_W-1:0] aluOp;
    memCtrlT            mem;
  } exCtrlT;

  typedef struct packed {
    logic   branch;
    logic   branchNe;
    logic   jump;
    exCtrlT ex;
  } ctrlBundleT;

  localparam ctrlBundleT NOP_BUNDLE = '0;

  function automatic logic isExtOp(input logic [OP_W-1:0] op);
    return (op == OP_BNE) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_SLTI) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/main_decoder_ext.sv
// Combinational opcode -> control bundle decoder with illegal-opcode detect;
// the extended opcodes decode as illegal when EN_EXT is clear.
module main_decoder_ext
  import ctrl_pkg::*;
#(
  parameter bit EN_EXT = 1'b1
) (
  input  logic [OP_W-1:0] opCode,
  output ctrlBundleT      bundle,
  output logic            illegal
);

  always_comb begin
    bundle  = NOP_BUNDLE;
    illegal = 1'b0;
    case (opCode)
      OP_LW: begin
        bundle.ex.mem.wb.regWrite = 1'b1;
        bundle.ex.mem.wb.memtoReg = 1'b1;
        bundle.ex.aluSrc          = 1'b1;
      end
      OP_SW: begin
        bundle.ex.mem.memWrite = 1'b1;
        bundle.ex.aluSrc       = 1'b1;
      end
      OP_RTYPE: begin
        bundle.ex.mem.wb.regWrite = 1'b1;
        bundle.ex.regDst          = 1'b1;
        bundle.ex.aluOp           = ALU_FUNCT;
      end
      OP_BEQ: begin
        bundle.branch   = 1'b1;
        bundle.ex.aluOp = ALU_SUB;
      end
      OP_BNE: begin
        bundle.branchNe = 1'b1;
        bundle.ex.aluOp = ALU_SUB;
      end
      OP_ADDI: begin
        bundle.ex.mem.wb.regWrite = 1'b1;
        bundle.ex.aluSrc          = 1'b1;
      end
      OP_ANDI: begin
        bundle.ex.mem.wb.regWrite = 1'b1;
        bundle.ex.aluSrc          = 1'b1;
        bundle.ex.aluOp           = ALU_AND;
      end
      OP_ORI: begin
        bundle.ex.mem.wb.regWrite = 1'b1;
        bundle.ex.aluSrc          = 1'b1;
        bundle.ex.aluOp           = ALU_OR;
      end
      OP_SLTI: begin
        bundle.ex.mem.wb.regWrite = 1'b1;
        bundle.ex.aluSrc          = 1'b1;
        bundle.ex.aluOp           = ALU_SLT;
      end
      OP_J: bundle.jump = 1'b1;
      OP_JAL: begin
        bundle.jump               = 1'b1;
        bundle.ex.mem.wb.regWrite = 1'b1;
        bundle.ex.mem.wb.link     = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Extended opcodes are treated exactly like unknown ones when disabled.
    if (!EN_EXT && isExtOp(opCode)) begin
      bundle  = NOP_BUNDLE;
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Main control for the 5-stage MIPS core: D-stage decode, ID/EX, EX/MEM, MEM/WB
// control registers, and a sticky illegal-opcode trap with a saturating counter.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter bit          EN_EXT = 1'b1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    OpCode,
  input  logic               StallD,
  input  logic               FlushE,
  input  logic               ExcAck,
  output logic               BranchD,
  output logic               BranchNeD,
  output logic               JumpD,
  output logic               RegWriteE,
  output logic               MemtoRegE,
  output logic               MemWriteE,
  output logic               ALUSrcE,
  output logic               RegDstE,
  output logic               LinkE,
  output logic [ALUOP_W-1:0] ALUOpE,
  output logic               RegWriteM,
  output logic               MemtoRegM,
  output logic               MemWriteM,
  output logic               LinkM,
  output logic               RegWriteW,
  output logic               MemtoRegW,
  output logic               LinkW,
  output logic               ExcPending,
  output logic [CNT_W-1:0]   IllegalCnt
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] TRAP = 1'b1;

  logic [0:0] state;
  logic [0:0] stateNext;
  ctrlBundleT decBundle;
  ctrlBundleT decodedD;
  logic       illegalD;
  logic       retireIllegal;
  exCtrlT     idEx;
  memCtrlT    exMem;
  wbCtrlT     memWb;

  main_decoder_ext #(.EN_EXT(EN_EXT)) uDecoder (
    .opCode  (OpCode),
    .bundle  (decBundle),
    .illegal (illegalD)
  );

  // An illegal opcode only counts once it actually leaves D while running.
  assign retireIllegal = (state == RUN) && illegalD && !StallD;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    decodedD  = decBundle;
    case (state)
      RUN: begin
        if (retireIllegal) stateNext = TRAP;
      end
      TRAP: begin
        decodedD = NOP_BUNDLE;
        if (ExcAck) stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      IllegalCnt <= '0;
    end else if (retireIllegal && (IllegalCnt != {CNT_W{1'b1}})) begin
      IllegalCnt <= IllegalCnt + CNT_W'(1);
    end
  end

  // Flush wins over stall; E/M/W always advance otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      idEx  <= NOP_BUNDLE.ex;
      exMem <= NOP_BUNDLE.ex.mem;
      memWb <= NOP_BUNDLE.ex.mem.wb;
    end else begin
      idEx  <= FlushE ? NOP_BUNDLE.ex : decodedD.ex;
      exMem <= idEx.mem;
      memWb <= exMem.wb;
    end
  end

  assign BranchD    = decodedD.branch;
  assign BranchNeD  = decodedD.branchNe;
  assign JumpD      = decodedD.jump;

  assign RegWriteE  = idEx.mem.wb.regWrite;
  assign MemtoRegE  = idEx.mem.wb.memtoReg;
  assign MemWriteE  = idEx.mem.memWrite;
  assign ALUSrcE    = idEx.aluSrc;
  assign RegDstE    = idEx.regDst;
  assign LinkE      = idEx.mem.wb.link;
  assign ALUOpE     = idEx.aluOp;

  assign RegWriteM  = exMem.wb.regWrite;
  assign MemtoRegM  = exMem.wb.memtoReg;
  assign MemWriteM  = exMem.memWrite;
  assign LinkM      = exMem.wb.link;

  assign RegWriteW  = memWb.regWrite;
  assign MemtoRegW  = memWb.memtoReg;
  assign LinkW      = memWb.link;

  assign ExcPending = (state == TRAP);

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench: two control pipelines (full ISA / 8-bit counter, and
// base ISA / 2-bit counter) share one stimulus stream and one behavioural model.
module tb_ctrl_pipeline;

  localparam logic [5:0] RT = 6'h00, JJ = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] ADDI = 6'h08, SLTI = 6'h0a, ANDI = 6'h0c, ORI = 6'h0d;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BAD = 6'h3f;

  typedef struct packed {
    logic       rw, m2r, mw, src, dst, link, br, bne, j;
    logic [2:0] alu;
  } mdlT;

  logic       clk = 1'b0;
  logic       rst, StallD, FlushE, ExcAck;
  logic [5:0] OpCode;

  wire [2:0] dObs0, dObs1;
  wire [8:0] eObs0, eObs1;
  wire [3:0] mObs0, mObs1;
  wire [2:0] wObs0, wObs1;
  wire       exc0, exc1;
  wire [7:0] cnt0;
  wire [1:0] cnt1;

  int total = 0;
  int bad   = 0;

  bit  trapM [2];
  int  cntM  [2];
  mdlT pipeE [2];
  mdlT pipeM [2];
  mdlT pipeW [2];
  bit  extEn [2]  = '{1'b1, 1'b0};
  int  cntMax[2]  = '{255, 3};
  logic [5:0] opList[11] = '{RT, JJ, JAL, BEQ, BNE, ADDI, SLTI, ANDI, ORI, LW, SW};

  always #5 clk = ~clk;

  ctrl_pipeline #(.EN_EXT(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .OpCode(OpCode), .StallD(StallD), .FlushE(FlushE), .ExcAck(ExcAck),
    .BranchD(dObs0[2]), .BranchNeD(dObs0[1]), .JumpD(dObs0[0]),
    .RegWriteE(eObs0[8]), .MemtoRegE(eObs0[7]), .MemWriteE(eObs0[6]), .ALUSrcE(eObs0[5]),
    .RegDstE(eObs0[4]), .LinkE(eObs0[3]), .ALUOpE(eObs0[2:0]),
    .RegWriteM(mObs0[3]), .MemtoRegM(mObs0[2]), .MemWriteM(mObs0[1]), .LinkM(mObs0[0]),
    .RegWriteW(wObs0[2]), .MemtoRegW(wObs0[1]), .LinkW(wObs0[0]),
    .ExcPending(exc0), .IllegalCnt(cnt0)
  );

  ctrl_pipeline #(.EN_EXT(1'b0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .OpCode(OpCode), .StallD(StallD), .FlushE(FlushE), .ExcAck(ExcAck),
    .BranchD(dObs1[2]), .BranchNeD(dObs1[1]), .JumpD(dObs1[0]),
    .RegWriteE(eObs1[8]), .MemtoRegE(eObs1[7]), .MemWriteE(eObs1[6]), .ALUSrcE(eObs1[5]),
    .RegDstE(eObs1[4]), .LinkE(eObs1[3]), .ALUOpE(eObs1[2:0]),
    .RegWriteM(mObs1[3]), .MemtoRegM(mObs1[2]), .MemWriteM(mObs1[1]), .LinkM(mObs1[0]),
    .RegWriteW(wObs1[2]), .MemtoRegW(wObs1[1]), .LinkW(wObs1[0]),
    .ExcPending(exc1), .IllegalCnt(cnt1)
  );

  // Instruction-set semantics expressed as opcode set membership.
  function automatic bit isLegal(input logic [5:0] op, input bit ext);
    bit known, isExt;
    known = op inside {RT, JJ, JAL, BEQ, BNE, ADDI, SLTI, ANDI, ORI, LW, SW};
    isExt = op inside {JAL, BNE, SLTI, ANDI, ORI};
    return known && (ext || !isExt);
  endfunction

  function automatic mdlT refDecode(input logic [5:0] op, input bit ext);
    mdlT b = '0;
    if (!isLegal(op, ext)) return b;
    b.rw   = op inside {RT, JAL, ADDI, SLTI, ANDI, ORI, LW};
    b.m2r  = (op == LW);
    b.mw   = (op == SW);
    b.src  = op inside {ADDI, SLTI, ANDI, ORI, LW, SW};
    b.dst  = (op == RT);
    b.link = (op == JAL);
    b.br   = (op == BEQ);
    b.bne  = (op == BNE);
    b.j    = op inside {JJ, JAL};
    if (op == RT)                b.alu = 3'd2;
    else if (op inside {BEQ, BNE}) b.alu = 3'd1;
    else if (op == ANDI)         b.alu = 3'd3;
    else if (op == ORI)          b.alu = 3'd4;
    else if (op == SLTI)         b.alu = 3'd5;
    else                         b.alu = 3'd0;
    return b;
  endfunction

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic checkRegs();
    for (int k = 0; k < 2; k++) begin
      chk("E", k, 16'(k == 0 ? eObs0 : eObs1),
          16'({pipeE[k].rw, pipeE[k].m2r, pipeE[k].mw, pipeE[k].src, pipeE[k].dst, pipeE[k].link, pipeE[k].alu}));
      chk("M", k, 16'(k == 0 ? mObs0 : mObs1), 16'({pipeM[k].rw, pipeM[k].m2r, pipeM[k].mw, pipeM[k].link}));
      chk("W", k, 16'(k == 0 ? wObs0 : wObs1), 16'({pipeW[k].rw, pipeW[k].m2r, pipeW[k].link}));
      chk("ExcPending", k, 16'(k == 0 ? exc0 : exc1), 16'(trapM[k]));
      chk("IllegalCnt", k, (k == 0) ? 16'(cnt0) : 16'(cnt1), 16'(cntM[k]));
    end
  endtask

  // One clock: drive, check D combinationally, clock, advance model, check registers.
  task automatic cycle(input logic [5:0] op, input logic stall, input logic flush,
                       input logic ack, input logic rstIn);
    mdlT d;
    OpCode = op; StallD = stall; FlushE = flush; ExcAck = ack; rst = rstIn;
    #1;
    for (int k = 0; k < 2; k++) begin
      d = trapM[k] ? mdlT'(0) : refDecode(op, extEn[k]);
      chk("D", k, 16'(k == 0 ? dObs0 : dObs1), 16'({d.br, d.bne, d.j}));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rstIn) begin
        trapM[k] = 1'b0; cntM[k] = 0;
        pipeE[k] = '0; pipeM[k] = '0; pipeW[k] = '0;
      end else begin
        d = trapM[k] ? mdlT'(0) : refDecode(op, extEn[k]);
        pipeW[k] = pipeM[k];
        pipeM[k] = pipeE[k];
        pipeE[k] = flush ? mdlT'(0) : d;
        if (!trapM[k] && !isLegal(op, extEn[k]) && !stall) begin
          trapM[k] = 1'b1;
          if (cntM[k] < cntMax[k]) cntM[k]++;
        end else if (trapM[k] && ack) begin
          trapM[k] = 1'b0;
        end
      end
    end
    #1;
    checkRegs();
  endtask

  initial begin
    logic [5:0] op;
    logic       st;
    OpCode = RT; StallD = 1'b0; FlushE = 1'b0; ExcAck = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      trapM[k] = 1'b0; cntM[k] = 0; pipeE[k] = '0; pipeM[k] = '0; pipeW[k] = '0;
    end
    cycle(RT, 0, 0, 0, 1);

    // lw flowing E -> M -> W
    cycle(LW, 0, 0, 0, 0);
    cycle(RT, 0, 0, 0, 0);
    cycle(BEQ, 0, 0, 0, 0);
    cycle(SW, 0, 0, 0, 0);
    // lw stalled with paired flush, then released
    cycle(LW, 1, 1, 0, 0);
    cycle(LW, 0, 0, 0, 0);
    cycle(ADDI, 0, 0, 0, 0);
    // jal: legal in dut0, trap in dut1
    cycle(JAL, 0, 0, 0, 0);
    cycle(ADDI, 0, 0, 0, 0);
    cycle(ORI, 0, 0, 0, 0);
    cycle(ADDI, 0, 0, 1, 0);
    cycle(ANDI, 0, 0, 0, 0);
    // illegal held under stall, then released and acknowledged
    repeat (3) cycle(BAD, 1, 1, 0, 0);
    cycle(BAD, 0, 0, 0, 0);
    cycle(ADDI, 0, 0, 0, 0);
    cycle(ADDI, 0, 0, 1, 0);
    repeat (3) cycle(ADDI, 0, 0, 0, 0);
    // five acknowledged illegals drive dut1's 2-bit counter into saturation
    repeat (5) begin
      cycle(BAD, 0, 0, 0, 0);
      cycle(RT, 0, 0, 1, 0);
    end
    // reset while trapped with live bundles in E/M/W
    cycle(LW, 0, 0, 0, 0);
    cycle(JAL, 0, 0, 0, 0);
    cycle(BAD, 0, 0, 0, 0);
    cycle(ADDI, 0, 0, 0, 1);
    cycle(RT, 0, 0, 0, 0);
    cycle(BNE, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      op = ($urandom_range(0, 1) == 0) ? opList[$urandom_range(0, 10)] : 6'($urandom);
      st = ($urandom_range(0, 5) == 0);
      cycle(op, st, st | ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
